// File: rtl/otter_io_pkg.sv
// Shared definitions for the Otter IOBUS peripheral block: address map,
// UART transmitter states and USTAT bit positions.
package otter_io_pkg;

  localparam logic [31:0] ADDR_SW    = 32'h1100_0000;
  localparam logic [31:0] ADDR_LED   = 32'h1100_0020;
  localparam logic [31:0] ADDR_TCNT  = 32'h1100_0040;
  localparam logic [31:0] ADDR_TCMP  = 32'h1100_0044;
  localparam logic [31:0] ADDR_UTX   = 32'h1100_0060;
  localparam logic [31:0] ADDR_USTAT = 32'h1100_0064;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int USTAT_EMPTY = 0;
  localparam int USTAT_FULL  = 1;
  localparam int USTAT_BUSY  = 2;
  localparam int USTAT_OVF   = 3;

endpackage

// File: rtl/otter_uart_tx.sv
// 8N1 UART transmitter, LSB first, with a registered TXD that idles high.
// Defining OTTER_UART_PARITY_EN inserts an even-parity bit before the stop bit.
module otter_uart_tx
  import otter_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       txd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par;
  logic          baud_done;

  assign baud_done = (baud == BAUD_LAST);
  assign ready     = (state == IDLE);
  assign busy      = !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      baud <= baud_done ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          baud <= '0;
          txd  <= 1'b1;
          if (valid) begin
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: if (baud_done) begin
          state   <= DATA;
          bit_idx <= '0;
          txd     <= shreg[0];
        end
        DATA: if (baud_done) begin
          if (bit_idx == 3'd7) begin
`ifdef OTTER_UART_PARITY_EN
            state <= PARITY;
            txd   <= par;
`else
            state <= STOP;
            txd   <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
            txd     <= shreg[1];
          end
        end
`ifdef OTTER_UART_PARITY_EN
        PARITY: if (baud_done) begin
          state <= STOP;
          txd   <= 1'b1;
        end
`endif
        STOP: if (baud_done) begin
          state <= IDLE;
          txd   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Payload path: loaded on accept, shifted right so bit 1 is always the next bit out.
  always_ff @(posedge clk) begin
    if (ready && valid) begin
      shreg <= data;
      par   <= ^data;
    end else if (state == DATA && baud_done) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: rtl/otter_iobus_periph.sv
// Otter IOBUS peripheral block: switches, LEDs, compare timer and FIFO-fed UART TX.
// Build option OTTER_UART_PARITY_EN enables an even-parity bit in each UART frame.
module otter_iobus_periph
  import otter_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int TMR_PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic [15:0] SWITCHES,
  output logic [15:0] LEDS,
  output logic        UART_TXD,
  output logic        TIMER_IRQ
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int PW  = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TMR_PRESCALE - 1);
  localparam logic [AW:0]   DEPTH    = AW1'(FIFO_DEPTH);

  logic [15:0]   sw_p0, sw_p1;
  logic [31:0]   tcnt, tcmp;
  logic [PW-1:0] pre;
  logic          tick, match;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, push, pop, accept, ovf;
  logic          tx_ready, tx_busy;
  logic          wr_led, wr_tcnt, wr_tcmp, wr_ustat;

  assign wr_led   = IOBUS_WR && (IOBUS_ADDR == ADDR_LED);
  assign wr_tcnt  = IOBUS_WR && (IOBUS_ADDR == ADDR_TCNT);
  assign wr_tcmp  = IOBUS_WR && (IOBUS_ADDR == ADDR_TCMP);
  assign wr_ustat = IOBUS_WR && (IOBUS_ADDR == ADDR_USTAT);
  assign push     = IOBUS_WR && (IOBUS_ADDR == ADDR_UTX);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
      LEDS  <= '0;
    end else begin
      sw_p0 <= SWITCHES;
      sw_p1 <= sw_p0;
      if (wr_led) LEDS <= IOBUS_OUT[15:0];
    end
  end

  // A TCNT write overrides the count update but never masks a coincident match pulse.
  assign tick  = (pre == PRE_LAST);
  assign match = tick && (tcmp != '0) && (tcnt == tcmp);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre       <= '0;
      tcnt      <= '0;
      tcmp      <= '0;
      TIMER_IRQ <= 1'b0;
    end else begin
      TIMER_IRQ <= match;
      if (wr_tcmp) tcmp <= IOBUS_OUT;
      if (wr_tcnt) begin
        tcnt <= '0;
        pre  <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (match)     tcnt <= '0;
        else if (tick) tcnt <= tcnt + 32'd1;
      end
    end
  end

  // Pop is evaluated before push, so a full FIFO still accepts when the UART drains it.
  assign empty  = (wptr == rptr);
  assign full   = ((wptr - rptr) == DEPTH);
  assign pop    = tx_ready && !empty;
  assign accept = push && (!full || pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (pop)    rptr <= rptr + 1'b1;
      if (accept) wptr <= wptr + 1'b1;
      if (wr_ustat)            ovf <= 1'b0;
      else if (push && !accept) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) fifo_mem[wptr[AW-1:0]] <= IOBUS_OUT[7:0];
  end

  otter_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (CLK),
    .rst_n(RESET_N),
    .valid(!empty),
    .data (fifo_mem[rptr[AW-1:0]]),
    .ready(tx_ready),
    .busy (tx_busy),
    .txd  (UART_TXD)
  );

  always_comb begin
    IOBUS_IN = '0;
    case (IOBUS_ADDR)
      ADDR_SW:   IOBUS_IN = {16'h0, sw_p1};
      ADDR_LED:  IOBUS_IN = {16'h0, LEDS};
      ADDR_TCNT: IOBUS_IN = tcnt;
      ADDR_TCMP: IOBUS_IN = tcmp;
      ADDR_USTAT: begin
        IOBUS_IN[USTAT_EMPTY] = empty;
        IOBUS_IN[USTAT_FULL]  = full;
        IOBUS_IN[USTAT_BUSY]  = tx_busy;
        IOBUS_IN[USTAT_OVF]   = ovf;
      end
      default: IOBUS_IN = '0;
    endcase
  end

endmodule

// File: tb/tb_otter_iobus_periph.sv
// Self-checking bench for otter_iobus_periph: bus decode, switches, timer,
// UART frames, FIFO overflow and reset during a frame.
module tb_otter_iobus_periph;

  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef OTTER_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [31:0] A_SW    = 32'h1100_0000;
  localparam logic [31:0] A_LED   = 32'h1100_0020;
  localparam logic [31:0] A_TCNT  = 32'h1100_0040;
  localparam logic [31:0] A_TCMP  = 32'h1100_0044;
  localparam logic [31:0] A_UTX   = 32'h1100_0060;
  localparam logic [31:0] A_USTAT = 32'h1100_0064;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic        IOBUS_WR;
  logic [15:0] SWITCHES, LEDS;
  logic        UART_TXD, TIMER_IRQ;

  int n_checks = 0;
  int n_errors = 0;
  int rst_evt  = 0;
  logic [7:0] rx_q[$];

  otter_iobus_periph #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TMR_PRESCALE(1)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .SWITCHES  (SWITCHES),
    .LEDS      (LEDS),
    .UART_TXD  (UART_TXD),
    .TIMER_IRQ (TIMER_IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
  endtask

  task automatic rd_bus(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK);
    IOBUS_ADDR = a;
    IOBUS_WR   = 1'b0;
    #1;
    d = IOBUS_IN;
  endtask

  // Expected line level for frame bit k: start, 8 data LSB first, [parity], stop.
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef OTTER_UART_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(negedge RESET_N) rst_evt++;

  // Serial receiver sampling mid-bit; frames cut by a reset are discarded.
  initial begin : uart_mon
    logic [7:0] b;
    logic       bad_start;
    int         ev;
    forever begin
      @(negedge UART_TXD);
      ev = rst_evt;
      repeat (CPB / 2) @(posedge CLK);
      #1;
      bad_start = (UART_TXD !== 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge CLK);
        #1;
        b[i] = UART_TXD;
      end
`ifdef OTTER_UART_PARITY_EN
      repeat (CPB) @(posedge CLK);
      #1;
      if (ev == rst_evt && RESET_N) chk("rx_parity", 32'(UART_TXD), 32'(^b));
`endif
      repeat (CPB) @(posedge CLK);
      #1;
      if (ev == rst_evt && RESET_N) begin
        chk("rx_start", 32'(bad_start), 32'd0);
        chk("rx_stop", 32'(UART_TXD), 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic [15:0] exp_led, sw_old, sw_new;
    logic [7:0]  b, b1;
    logic [7:0]  exp_q[$];
    int          c, len, lows, r;

    RESET_N = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0; SWITCHES = '0;
    repeat (3) @(negedge CLK);
    chk("rst_leds", 32'(LEDS), 32'd0);
    chk("rst_txd", 32'(UART_TXD), 32'd1);
    chk("rst_irq", 32'(TIMER_IRQ), 32'd0);
    IOBUS_ADDR = A_USTAT; #1;
    chk("rst_ustat", IOBUS_IN, 32'h1);
    IOBUS_ADDR = A_TCNT; #1;
    chk("rst_tcnt", IOBUS_IN, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // LED register and decode
    wr_bus(A_LED, 32'h0000_A5F0);
    chk("led_a5f0", 32'(LEDS), 32'h0000_A5F0);
    rd_bus(A_LED, rd);
    chk("led_rd_a5f0", rd, 32'h0000_A5F0);
    rd_bus(32'h1100_0010, rd);
    chk("rd_unmapped_10", rd, 32'h0);
    rd_bus(A_UTX, rd);
    chk("rd_utx", rd, 32'h0);
    exp_led = 16'hA5F0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      wr_bus(A_LED, a);
      exp_led = a[15:0];
      chk("led_wr", 32'(LEDS), 32'(exp_led));
      rd_bus(A_LED, rd);
      chk("led_rd", rd, {16'h0, exp_led});
      r = $urandom_range(24, 0);
      if (r >= 5) r = r + 2;
      a = A_LED ^ (32'h1 << r);
      wr_bus(a, $urandom);
      chk("led_nearmiss_wr", 32'(LEDS), 32'(exp_led));
      rd_bus(a, rd);
      chk("rd_nearmiss", rd, 32'h0);
    end

    // Switch synchroniser latency
    sw_old = 16'h0;
    for (int i = 0; i < 4; i++) begin
      sw_new = 16'($urandom);
      @(negedge CLK);
      SWITCHES = sw_new; IOBUS_ADDR = A_SW; #1;
      chk("sw_lat0", IOBUS_IN, {16'h0, sw_old});
      @(negedge CLK); #1;
      chk("sw_lat1", IOBUS_IN, {16'h0, sw_old});
      @(negedge CLK); #1;
      chk("sw_lat2", IOBUS_IN, {16'h0, sw_new});
      sw_old = sw_new;
    end

    // Timer: count runs 0..C, wraps to 0 with a one-cycle IRQ
    for (int t = 0; t < 3; t++) begin
      c = (t == 0) ? 5 : int'($urandom_range(12, 2));
      wr_bus(A_TCNT, $urandom);
      wr_bus(A_TCMP, c);
      wr_bus(A_TCNT, $urandom);
      len = 3 * (c + 1) + c;
      for (int k = 0; k < len; k++) begin
        rd_bus(A_TCNT, rd);
        chk("tcnt", rd, k % (c + 1));
        chk("irq", 32'(TIMER_IRQ), 32'(k > 0 && (k % (c + 1)) == 0));
      end
      wr_bus(A_TCNT, $urandom);
      rd_bus(A_TCNT, rd);
      chk("tcnt_wr_at_match", rd, 32'h0);
      chk("irq_wr_at_match", 32'(TIMER_IRQ), 32'd1);
      rd_bus(A_TCNT, rd);
      chk("tcnt_after_match", rd, 32'h1);
      chk("irq_after_match", 32'(TIMER_IRQ), 32'd0);
      rd_bus(A_TCMP, rd);
      chk("tcmp_rd", rd, c);
    end
    wr_bus(A_TCMP, 32'h0);
    wr_bus(A_TCNT, 32'h0);
    for (int k = 0; k < 10; k++) begin
      rd_bus(A_TCNT, rd);
      chk("tcnt_nocmp", rd, k);
      chk("irq_nocmp", 32'(TIMER_IRQ), 32'd0);
    end

    // Single UART frames, checked cycle by cycle
    b1 = 8'h0;
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'h55 : 8'($urandom);
      if (t == 0) b1 = b;
      wr_bus(A_UTX, {24'($urandom), b});
      rd_bus(A_USTAT, rd);
      chk("ustat_queued", rd, 32'h0);
      chk("tx_pre", 32'(UART_TXD), 32'd1);
      for (int i = 0; i < NBITS * CPB; i++) begin
        @(negedge CLK);
        chk("tx_bit", 32'(UART_TXD), 32'(fbit(b, i / CPB)));
        if (i == CPB) chk("ustat_busy", IOBUS_IN, 32'h5);
      end
      rd_bus(A_USTAT, rd);
      chk("ustat_idle", rd, 32'h1);
      chk("tx_idle", 32'(UART_TXD), 32'd1);
    end
    chk("rx_count2", rx_q.size(), 32'd2);
    if (rx_q.size() == 2) begin
      chk("rx_byte0", 32'(rx_q[0]), 32'(b1));
      chk("rx_byte1", 32'(rx_q[1]), 32'(b));
    end
    rx_q.delete();

    // FIFO overflow: one byte goes to the shifter, DEPTH are held, the rest drop
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom);
      wr_bus(A_UTX, {24'h0, b});
      if (i < DEPTH + 1) exp_q.push_back(b);
    end
    rd_bus(A_USTAT, rd);
    chk("ustat_ovf", rd, 32'hE);
    wr_bus(A_USTAT, $urandom);
    rd_bus(A_USTAT, rd);
    chk("ustat_ovf_clr", rd, 32'h6);
    for (int w = 0; w < 600 && rx_q.size() < DEPTH + 1; w++) @(negedge CLK);
    repeat (3 * NBITS * CPB) @(negedge CLK);
    chk("ovf_frames", rx_q.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < rx_q.size(); i++)
      chk("ovf_byte", 32'(rx_q[i]), 32'(exp_q[i]));
    rd_bus(A_USTAT, rd);
    chk("ustat_drained", rd, 32'h1);
    rx_q.delete();

    // Reset during DATA of 0x3C aborts the frame and flushes the FIFO
    wr_bus(A_LED, 32'h1234);
    wr_bus(A_UTX, 32'h3C);
    wr_bus(A_UTX, $urandom);
    wr_bus(A_UTX, $urandom);
    repeat (4) @(negedge CLK);
    chk("pre_rst_txd", 32'(UART_TXD), 32'd0);
    RESET_N = 1'b0;
    #1;
    chk("rst_async_txd", 32'(UART_TXD), 32'd1);
    chk("rst_async_leds", 32'(LEDS), 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    rd_bus(A_USTAT, rd);
    chk("ustat_after_rst", rd, 32'h1);
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      if (UART_TXD !== 1'b1) lows++;
    end
    chk("no_frame_after_rst", lows, 32'd0);
    chk("rx_after_rst", rx_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
